// File: rtl/mul_div_unit_if.sv
// Request/result bundle between an issuing pipeline and mul_div_unit.
// The master drives start/op/a/b; the slave returns busy/done/divzero and HI/LO.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             divzero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, divzero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, divzero, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: 32-cycle shift-add multiply, 32-cycle restoring divide.
// Divide support is compiled only when MULDIV_DIVIDE_EN is defined; otherwise DIV/DIVU are ignored.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  mul_div_unit_if.slave  bus
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MULDIV_DIVIDE_EN
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
`endif

`ifdef MULDIV_DIVIDE_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_FIX = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_FIX = 2'd3} state_t;
`endif

  state_t             state_q, state_d;
  logic [5:0]         cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opb_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               neg_q;
  logic               done_q;

  logic               is_signed;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic               load_mul, wr_hi, wr_lo;
  logic               last_iter;

  // Only the signed forms take magnitudes; result sign is restored in FIX.
  assign is_signed = (bus.op == OP_MULT)
`ifdef MULDIV_DIVIDE_EN
                     || (bus.op == OP_DIV)
`endif
                     ;
  assign abs_a     = (is_signed && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
  assign abs_b     = (is_signed && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;
  assign last_iter = (cnt_q == 6'd31);

  // Shift-add step: low half holds the remaining multiplier bits, high half the partial sum.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] prod_fix;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;

`ifdef MULDIV_DIVIDE_EN
  logic               load_div;
  logic               is_div_q, neg_r_q, dz_q, divzero_q;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Restoring step on {remainder, dividend/quotient}: quotient bits enter at the bottom.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_ge    = (div_shift >= {1'b0, opb_q});
  assign div_next  = div_ge ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                            : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
  assign quo_fix   = neg_q   ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
  assign rem_fix   = neg_r_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
`endif

  always_comb begin
    state_d  = state_q;
    load_mul = 1'b0;
    wr_hi    = 1'b0;
    wr_lo    = 1'b0;
`ifdef MULDIV_DIVIDE_EN
    load_div = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MULT, OP_MULTU: begin
              load_mul = 1'b1;
              state_d  = S_MUL;
            end
`ifdef MULDIV_DIVIDE_EN
            OP_DIV, OP_DIVU: begin
              load_div = 1'b1;
              state_d  = S_DIV;
            end
`endif
            OP_MTHI: wr_hi = 1'b1;
            OP_MTLO: wr_lo = 1'b1;
            default: ;
          endcase
        end
      end
      S_MUL: if (last_iter) state_d = S_FIX;
`ifdef MULDIV_DIVIDE_EN
      S_DIV: if (last_iter) state_d = S_FIX;
`endif
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      acc_q     <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_q     <= 1'b0;
      done_q    <= 1'b0;
`ifdef MULDIV_DIVIDE_EN
      is_div_q  <= 1'b0;
      neg_r_q   <= 1'b0;
      dz_q      <= 1'b0;
      divzero_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      done_q    <= 1'b0;
`ifdef MULDIV_DIVIDE_EN
      divzero_q <= 1'b0;
`endif
      if (load_mul) begin
        acc_q    <= {{WIDTH{1'b0}}, abs_b};
        opb_q    <= abs_a;
        neg_q    <= is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        cnt_q    <= 6'd0;
`ifdef MULDIV_DIVIDE_EN
        is_div_q <= 1'b0;
`endif
      end
`ifdef MULDIV_DIVIDE_EN
      if (load_div) begin
        acc_q    <= {{WIDTH{1'b0}}, abs_a};
        opb_q    <= abs_b;
        neg_q    <= is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        neg_r_q  <= is_signed && bus.a[WIDTH-1];
        dz_q     <= (bus.b == '0);
        cnt_q    <= 6'd0;
        is_div_q <= 1'b1;
      end
`endif
      if (wr_hi) hi_q <= bus.a;
      if (wr_lo) lo_q <= bus.a;

      case (state_q)
        S_MUL: begin
          acc_q <= mul_next;
          cnt_q <= cnt_q + 6'd1;
        end
`ifdef MULDIV_DIVIDE_EN
        S_DIV: begin
          acc_q <= div_next;
          cnt_q <= cnt_q + 6'd1;
        end
`endif
        S_FIX: begin
          done_q <= 1'b1;
          cnt_q  <= 6'd0;
`ifdef MULDIV_DIVIDE_EN
          // A zero divisor keeps HI/LO intact and only raises the flag.
          if (is_div_q) begin
            if (dz_q) begin
              divzero_q <= 1'b1;
            end else begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
`else
          hi_q <= prod_fix[2*WIDTH-1:WIDTH];
          lo_q <= prod_fix[WIDTH-1:0];
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
`ifdef MULDIV_DIVIDE_EN
  assign bus.divzero = divzero_q;
`else
  assign bus.divzero = 1'b0;
`endif

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit; divide vectors run only when MULDIV_DIVIDE_EN is defined.
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic reset;
  int   ncmp  = 0;
  int   nfail = 0;

  mul_div_unit_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    tick();
    bus.start = 1'b0;
  endtask

  // Called just after the accepting edge; returns edges until done and busy samples seen.
  task automatic run_until_done(output int n, output int busy_cnt);
    n = 0;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && n < 60) begin
      if (bus.busy === 1'b1) busy_cnt++;
      tick();
      n++;
    end
  endtask

  int n, bc, seen_done, seen_busy;

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = '0;
    bus.b     = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_hi", bus.hi, 0);
    chk("reset_lo", bus.lo, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_divzero", bus.divzero, 0);

    // MULT -3 * 7, with a MULTU 1*1 request thrown at it mid-operation
    issue(3'b000, 32'hFFFF_FFFD, 32'h0000_0007);
    chk("mult_busy_k", bus.busy, 1);
    n = 0;
    while (bus.done !== 1'b1 && n < 60) begin
      if (n == 5) begin
        bus.start = 1'b1; bus.op = 3'b001; bus.a = 32'h1; bus.b = 32'h1;
      end else begin
        bus.start = 1'b0;
      end
      if (n == 20) begin
        chk("mult_hold_hi", bus.hi, 0);
        chk("mult_hold_lo", bus.lo, 0);
      end
      tick();
      n++;
    end
    chk("mult_latency", n, 33);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFEB);
    chk("mult_busy_done", bus.busy, 0);
    chk("mult_divzero", bus.divzero, 0);

    // MULTU issued in the done cycle: accepted with no busy gap
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("b2b_busy", bus.busy, 1);
    run_until_done(n, bc);
    chk("multu_latency", n, 33);
    chk("multu_busy_cycles", bc, 33);
    chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
    chk("multu_lo", bus.lo, 32'h0000_0001);
    chk("multu_busy_done", bus.busy, 0);
    tick();
    chk("done_pulse_len", bus.done, 0);

    // MTHI then MTLO on consecutive cycles
    bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'h1234_5678;
    tick();
    chk("mthi_hi", bus.hi, 32'h1234_5678);
    chk("mthi_lo", bus.lo, 32'h0000_0001);
    chk("mthi_busy", bus.busy, 0);
    chk("mthi_done", bus.done, 0);
    bus.op = 3'b101; bus.a = 32'h9ABC_DEF0;
    tick();
    bus.start = 1'b0;
    chk("mtlo_lo", bus.lo, 32'h9ABC_DEF0);
    chk("mtlo_hi", bus.hi, 32'h1234_5678);
    chk("mtlo_busy", bus.busy, 0);
    chk("mtlo_done", bus.done, 0);

    // Reserved op leaves everything alone
    issue(3'b110, 32'hDEAD_BEEF, 32'h1);
    chk("rsvd_busy", bus.busy, 0);
    tick();
    chk("rsvd_done", bus.done, 0);
    chk("rsvd_hi", bus.hi, 32'h1234_5678);
    chk("rsvd_lo", bus.lo, 32'h9ABC_DEF0);

`ifdef MULDIV_DIVIDE_EN
    issue(3'b010, 32'hFFFF_FFF9, 32'h0000_0002);
    run_until_done(n, bc);
    chk("div_latency", n, 33);
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);
    chk("div_divzero", bus.divzero, 0);

    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    run_until_done(n, bc);
    chk("divovf_lo", bus.lo, 32'h8000_0000);
    chk("divovf_hi", bus.hi, 32'h0000_0000);
    chk("divovf_divzero", bus.divzero, 0);

    issue(3'b011, 32'd100, 32'd0);
    run_until_done(n, bc);
    chk("divz_latency", n, 33);
    chk("divz_flag", bus.divzero, 1);
    chk("divz_hi", bus.hi, 32'h0000_0000);
    chk("divz_lo", bus.lo, 32'h8000_0000);
    tick();
    chk("divz_pulse_len", bus.divzero, 0);
`else
    issue(3'b011, 32'd10, 32'd3);
    chk("nodiv_busy", bus.busy, 0);
    seen_done = 0;
    seen_busy = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) seen_done++;
      if (bus.busy === 1'b1) seen_busy++;
      tick();
    end
    chk("nodiv_no_done", seen_done, 0);
    chk("nodiv_no_busy", seen_busy, 0);
    chk("nodiv_hi", bus.hi, 32'h1234_5678);
    chk("nodiv_lo", bus.lo, 32'h9ABC_DEF0);
`endif

    // Reset on iteration cycle 10 aborts; start held during reset is not accepted
    issue(3'b000, 32'd5, 32'd6);
    for (int i = 0; i < 10; i++) tick();
    chk("abort_busy_before", bus.busy, 1);
    reset = 1'b1;
    bus.start = 1'b1; bus.op = 3'b000;
    tick();
    reset = 1'b0;
    bus.start = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_hi", bus.hi, 0);
    chk("abort_lo", bus.lo, 0);
    chk("abort_done", bus.done, 0);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) seen_done++;
      tick();
    end
    chk("abort_no_done", seen_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
